pc_desvio_unit: RTL
===================

PC_DESVIO_UNIT -- requirements
Module: pc_desvio_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and target width in bits, minimum 8.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, a power of two, minimum 2.
REQ-004 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port Stall  in  1  hold PC and state this cycle.
REQ-007 SHALL have port Result_AND  in  1  conditional branch taken (Branch AND Zero).
REQ-008 SHALL have port Jump  in  1  unconditional jump to Jump_Target.
REQ-009 SHALL have port Jump_Reg  in  1  register jump to Reg_Target.
REQ-010 SHALL have port Call  in  1  qualifies Jump as a call, pushing the link address.
REQ-011 SHALL have port Ret  in  1  qualifies Jump_Reg as a return, popping the stack.
REQ-012 SHALL have port Exit_ALU_Desvio  in  WIDTH  branch target.
REQ-013 SHALL have port Jump_Target  in  WIDTH  jump target.
REQ-014 SHALL have port Reg_Target  in  WIDTH  register-jump target.
REQ-015 SHALL have port Pc  out  WIDTH  current PC (registered).
REQ-016 SHALL have port Exit_ALU_Pc  out  WIDTH  Pc+4, combinational.
REQ-017 SHALL have port Flush  out  1  registered; high for the cycle after a redirect.
REQ-018 SHALL have port Misaligned  out  1  registered; high for the cycle after a target with bits[1:0] not equal to 0 was taken.
REQ-019 SHALL have port Ras_Empty  out  1  return-address stack holds no entries.

Function
REQ-020 SHALL select the next PC by priority: Jump_Reg, then Jump, then Result_AND, then Exit_ALU_Pc.
REQ-021 SHALL compute Exit_ALU_Pc as Pc+4, wrapping modulo 2^WIDTH.
REQ-022 SHALL force bits[1:0] of every taken target to 0 before loading it into Pc.
REQ-023 SHALL assert Misaligned for exactly one cycle after a target with bits[1:0] not equal to 0 was taken.
REQ-024 SHALL, when Stall=1, hold Pc, FSM state, stack, Flush and Misaligned, and ignore all control inputs.
REQ-025 SHALL implement an FSM with states RUN and FLUSH.
REQ-026 SHALL move RUN->FLUSH on any taken non-sequential selection without Stall.
REQ-027 SHALL move FLUSH->RUN when no redirect occurs; a redirect while in FLUSH SHALL keep the FSM in FLUSH.
REQ-028 SHALL drive Flush=1 exactly while the FSM is in FLUSH.
REQ-029 SHALL have a redirect latency of one cycle: the target appears on Pc at the edge following the request.

Reset
REQ-030 SHALL, on reset low, immediately set Pc=RESET_PC, state=RUN, Flush=0, Misaligned=0, stack pointer=0 and Ras_Empty=1, regardless of clock.
REQ-031 SHALL, on reset release, have its first update at the next rising clock edge using Exit_ALU_Pc=RESET_PC+4.
REQ-032 SHALL, on reset mid-redirect or mid-flush, discard the pending redirect and stack contents.

Configuration
REQ-033 SHALL compile the return-address stack only when macro PC_DESVIO_RAS_EN is defined.
REQ-034 SHALL, with PC_DESVIO_RAS_EN defined and Jump&Call taken, push Exit_ALU_Pc onto the stack.
REQ-035 SHALL, with PC_DESVIO_RAS_EN defined, Jump&Call taken and the stack full, overwrite the oldest entry (circular) and keep the depth at RAS_DEPTH.
REQ-036 SHALL, with PC_DESVIO_RAS_EN defined, Jump_Reg&Ret and the stack non-empty, use the top-of-stack as the target and pop it.
REQ-037 SHALL, with PC_DESVIO_RAS_EN defined, Jump_Reg&Ret and the stack empty, use Reg_Target and leave the stack unchanged.
REQ-038 SHALL, without PC_DESVIO_RAS_EN, ignore Call and Ret, use Reg_Target for all register jumps, and tie Ras_Empty to 1.

Verification
REQ-039 SHALL cover reset: reset low with clock running -> Pc=0, Flush=0, Ras_Empty=1; release -> Pc=4, then 8.
REQ-040 SHALL cover branch: Pc=0x10, Result_AND=1, Exit_ALU_Desvio=0x40 -> next Pc=0x40 and Flush=1 for one cycle; without the branch, Pc=0x14.
REQ-041 SHALL cover priority: Jump_Reg=1, Jump=1, Result_AND=1, Reg_Target=0x100 -> Pc=0x100.
REQ-042 SHALL cover stall: Stall=1 with Result_AND=1 for 3 cycles -> Pc and Flush unchanged; release -> redirect occurs.
REQ-043 SHALL cover wrap and misalignment: Pc=0xFFFFFFFC sequential -> Pc=0; then Jump_Target=0x203 -> Pc=0x200 and Misaligned=1 for one cycle.
REQ-044 SHALL cover the stack (PC_DESVIO_RAS_EN): 5 calls from Pc=0x0,0x10,0x20,0x30,0x40 -> 4 returns yield 0x44,0x34,0x24,0x14 -> 5th return uses Reg_Target and Ras_Empty=1.

Source files
------------

// File: rtl/pc_desvio_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_desvio_unit
//  Purpose  : Program-counter unit. It selects the next PC from the
//             register-jump, jump, branch and sequential sources, in that
//             priority order. Redirects are followed by a one-cycle flush
//             indication and a one-cycle misalignment flag.
//  Options  : Define PC_DESVIO_RAS_EN to build the circular return-address
//             stack (Call pushes, Ret pops). Without it, Call and Ret are
//             ignored and Ras_Empty is tied high.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_desvio_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Result_AND,
  input  logic             Jump,
  input  logic             Jump_Reg,
  input  logic             Call,
  input  logic             Ret,
  input  logic [WIDTH-1:0] Exit_ALU_Desvio,
  input  logic [WIDTH-1:0] Jump_Target,
  input  logic [WIDTH-1:0] Reg_Target,
  output logic [WIDTH-1:0] Pc,
  output logic [WIDTH-1:0] Exit_ALU_Pc,
  output logic             Flush,
  output logic             Misaligned,
  output logic             Ras_Empty
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic             w_ras_hit;   // a return that can be served from the stack
  logic [WIDTH-1:0] w_ras_top;

  // Sequential successor; wraps naturally modulo 2^WIDTH
  assign Exit_ALU_Pc = pc_q + WIDTH'(4);

  // Next-PC source selection by fixed priority
  always_comb begin
    w_redirect = 1'b1;
    w_target   = Exit_ALU_Pc;
    if (Jump_Reg) begin
      w_target = w_ras_hit ? w_ras_top : Reg_Target;
    end else if (Jump) begin
      w_target = Jump_Target;
    end else if (Result_AND) begin
      w_target = Exit_ALU_Desvio;
    end else begin
      w_redirect = 1'b0;
    end
  end

  // PC and misalignment next values; a stall freezes both
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (!Stall) begin
      // Taken targets are word-aligned by dropping the two low bits
      pc_d         = w_redirect ? {w_target[WIDTH-1:2], 2'b00} : w_target;
      misaligned_d = w_redirect && (w_target[1:0] != 2'b00);
    end
  end

  // PC and misalignment registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: any unstalled redirect enters or stays in FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (!Stall && w_redirect)  state_d = ST_FLUSH;
      ST_FLUSH: if (!Stall && !w_redirect) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    Flush      = (state_q == ST_FLUSH);
    Pc         = pc_q;
    Misaligned = misaligned_q;
  end

`ifdef PC_DESVIO_RAS_EN
  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  // The write pointer marks the next free slot. Once the stack is full it
  // also points at the oldest entry, so a push silently overwrites it.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_push;
  logic             w_pop;

  assign w_top_idx = wr_ptr_q - PTR_W'(1);
  assign w_ras_top = ras_q[w_top_idx];
  assign w_ras_hit = Ret && (count_q != '0);
  assign w_push    = Jump && !Jump_Reg && Call;
  assign w_pop     = Jump_Reg && w_ras_hit;
  assign Ras_Empty = (count_q == '0);

  // Stack update: push the link address on a call and pop on a served return
  always_comb begin
    ras_d    = ras_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (!Stall) begin
      if (w_push) begin
        ras_d[wr_ptr_q] = Exit_ALU_Pc;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (count_q != DEPTH_C) count_d = count_q + (PTR_W + 1)'(1);
      end else if (w_pop) begin
        wr_ptr_d = w_top_idx;
        count_d  = count_q - (PTR_W + 1)'(1);
      end
    end
  end

  // Stack storage and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ras_q    <= ras_d;
    end
  end
`else
  // Call and Ret qualify nothing without a stack
  logic w_unused_ras_ctrl;
  assign w_unused_ras_ctrl = Call ^ Ret ^ (RAS_DEPTH != 0);
  assign w_ras_hit         = 1'b0;
  assign w_ras_top         = '0;
  assign Ras_Empty         = 1'b1;
`endif

endmodule
`default_nettype wire
